// File: rtl/sram_arb_if.sv
// sram_arb_if: SRAM-like request/response port bundle.
// master drives req/wr/wstrb/addr/wdata and receives addr_ok/data_ok/rdata;
// slave is the opposite side. Used for the fetch, load/store and memory ports.
interface sram_arb_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  logic              req;
  logic              wr;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arb.sv
// sram_arb: arbitrates an instruction-fetch port and a load/store port onto
// a single SRAM-like memory port, one transaction outstanding at a time.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   flush        cancels the instruction-side response / suppresses inst grants
//   inst         fetch port (slave; only req/addr are used, reads only)
//   data         load/store port (slave)
//   m            shared memory port (master)
// Configuration: define SRAM_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise data always wins over inst.
module sram_arb (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  sram_arb_if.slave   inst,
  sram_arb_if.slave   data,
  sram_arb_if.master  m
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } hold_t;

  state_t state, state_nxt;
  hold_t  hold_q, hold_nxt;
  logic   owner_inst_q, owner_inst_nxt;
  logic   cancel_q, cancel_nxt;
  logic   inst_elig;
  logic   grant_inst;
  logic   grant_data;
  logic   inst_done;
  logic   data_done;

`ifdef SRAM_ARB_RR_EN
  logic   prio_data_q, prio_data_nxt;
`endif

  // State and holding registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      hold_q       <= '0;
      owner_inst_q <= 1'b0;
      cancel_q     <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      prio_data_q  <= 1'b1;
`endif
    end else begin
      state        <= state_nxt;
      hold_q       <= hold_nxt;
      owner_inst_q <= owner_inst_nxt;
      cancel_q     <= cancel_nxt;
`ifdef SRAM_ARB_RR_EN
      prio_data_q  <= prio_data_nxt;
`endif
    end
  end

  // Next-state, arbitration and capture
  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold_q;
    owner_inst_nxt = owner_inst_q;
    cancel_nxt     = cancel_q;
    grant_inst     = 1'b0;
    grant_data     = 1'b0;
`ifdef SRAM_ARB_RR_EN
    prio_data_nxt  = prio_data_q;
`endif
    // A flushed fetch is never granted in the first place
    inst_elig      = inst.req & ~flush;

    case (state)
      IDLE: begin
        cancel_nxt = 1'b0;
        // resetn gating keeps addr_ok low while reset is asserted
        if (resetn) begin
          if (data.req && inst_elig) begin
`ifdef SRAM_ARB_RR_EN
            grant_data = prio_data_q;
`else
            grant_data = 1'b1;
`endif
            grant_inst = ~grant_data;
          end else begin
            grant_data = data.req;
            grant_inst = inst_elig;
          end
        end

        if (grant_data) begin
          hold_nxt       = '{wr: data.wr, wstrb: data.wstrb,
                             addr: data.addr, wdata: data.wdata};
          owner_inst_nxt = 1'b0;
          state_nxt      = REQ;
`ifdef SRAM_ARB_RR_EN
          prio_data_nxt  = 1'b0;
`endif
        end else if (grant_inst) begin
          hold_nxt       = '{wr: 1'b0, wstrb: '0, addr: inst.addr, wdata: '0};
          owner_inst_nxt = 1'b1;
          state_nxt      = REQ;
`ifdef SRAM_ARB_RR_EN
          prio_data_nxt  = 1'b1;
`endif
        end
      end

      REQ: begin
        if (owner_inst_q && flush) cancel_nxt = 1'b1;
        if (m.addr_ok) state_nxt = RESP;
      end

      RESP: begin
        if (owner_inst_q && flush) cancel_nxt = 1'b1;
        if (m.data_ok) begin
          cancel_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Completion: only m.data_ok seen in RESP counts; a flush in the completing
  // cycle also suppresses the fetch response
  assign inst_done = (state == RESP) && m.data_ok && owner_inst_q &&
                     !cancel_q && !flush;
  assign data_done = (state == RESP) && m.data_ok && !owner_inst_q;

  assign inst.addr_ok = grant_inst;
  assign data.addr_ok = grant_data;
  assign inst.data_ok = inst_done;
  assign data.data_ok = data_done;
  assign inst.rdata   = inst_done ? m.rdata : '0;
  assign data.rdata   = data_done ? m.rdata : '0;

  assign m.req   = (state == REQ);
  assign m.wr    = hold_q.wr;
  assign m.wstrb = hold_q.wstrb;
  assign m.addr  = hold_q.addr;
  assign m.wdata = hold_q.wdata;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: self-checking bench for sram_arb (default fixed-priority build).
// Inputs change 1 ns after the rising edge; outputs are checked on the falling
// edge. Expected responses are queued when a grant is observed and consumed by
// a monitor whenever either data_ok pulses.
module tb_sram_arb;

  typedef struct packed {
    logic        is_inst;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic resetn;
  logic flush;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;

  sram_arb_if inst_bus ();
  sram_arb_if data_bus ();
  sram_arb_if m_bus ();

  sram_arb dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .inst   (inst_bus),
    .data   (data_bus),
    .m      (m_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Response monitor: every data_ok pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (inst_bus.data_ok || data_bus.data_ok) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected inst_ok=%b data_ok=%b", inst_bus.data_ok, data_bus.data_ok);
      end else begin
        e = sb.pop_front();
        if (e.is_inst) begin
          if (!inst_bus.data_ok || data_bus.data_ok) begin
            errors++;
            $display("FAIL sb_side got inst_ok=%b data_ok=%b want inst", inst_bus.data_ok, data_bus.data_ok);
          end else if (inst_bus.rdata !== e.rdata) begin
            errors++;
            $display("FAIL sb_inst_rdata got %h want %h", inst_bus.rdata, e.rdata);
          end
        end else begin
          if (!data_bus.data_ok || inst_bus.data_ok) begin
            errors++;
            $display("FAIL sb_side got inst_ok=%b data_ok=%b want data", inst_bus.data_ok, data_bus.data_ok);
          end else if (e.chk && data_bus.rdata !== e.rdata) begin
            errors++;
            $display("FAIL sb_data_rdata got %h want %h", data_bus.rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush          = 1'b0;
    inst_bus.req   = 1'b0;
    inst_bus.wr    = 1'b0;
    inst_bus.wstrb = 4'h0;
    inst_bus.addr  = 32'h0;
    inst_bus.wdata = 32'h0;
    data_bus.req   = 1'b0;
    data_bus.wr    = 1'b0;
    data_bus.wstrb = 4'h0;
    data_bus.addr  = 32'h0;
    data_bus.wdata = 32'h0;
    m_bus.addr_ok  = 1'b0;
    m_bus.data_ok  = 1'b0;
    m_bus.rdata    = 32'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    inst_bus.req = 1'b1;
    data_bus.req = 1'b1;
    m_bus.addr_ok = 1'b1;
    m_bus.data_ok = 1'b1;
    @(negedge clk);
    checks++; if (m_bus.req !== 1'b0) begin errors++; $display("FAIL rst_m_req got %b want 0", m_bus.req); end
    checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL rst_inst_addr_ok got %b want 0", inst_bus.addr_ok); end
    checks++; if (data_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL rst_data_addr_ok got %b want 0", data_bus.addr_ok); end
    checks++; if (m_bus.addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr got %h want 0", m_bus.addr); end
    step();
    clear_inputs();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_inst_fetch();
    m_bus.addr_ok = 1'b1;
    m_bus.data_ok = 1'b1;
    m_bus.rdata   = 32'h3C1D0001;
    inst_bus.req  = 1'b1;
    inst_bus.addr = 32'hBFC00000;
    @(negedge clk);
    checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL fetch_addr_ok got %b want 1", inst_bus.addr_ok); end
    checks++; if (m_bus.req !== 1'b0) begin errors++; $display("FAIL fetch_m_req_c0 got %b want 0", m_bus.req); end
    sb.push_back('{is_inst: 1'b1, chk: 1'b1, rdata: 32'h3C1D0001});
    step();
    inst_bus.req = 1'b0;
    @(negedge clk);
    checks++; if (m_bus.req !== 1'b1) begin errors++; $display("FAIL fetch_m_req_c1 got %b want 1", m_bus.req); end
    checks++; if (m_bus.addr !== 32'hBFC00000) begin errors++; $display("FAIL fetch_m_addr got %h want bfc00000", m_bus.addr); end
    checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL fetch_early_data_ok got %b want 0", inst_bus.data_ok); end
    step();
    @(negedge clk);
    checks++; if (inst_bus.data_ok !== 1'b1) begin errors++; $display("FAIL fetch_data_ok_c2 got %b want 1", inst_bus.data_ok); end
    checks++; if (m_bus.req !== 1'b0) begin errors++; $display("FAIL fetch_m_req_c2 got %b want 0", m_bus.req); end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fetch_sb_left got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_priority();
    m_bus.addr_ok  = 1'b1;
    m_bus.data_ok  = 1'b1;
    m_bus.rdata    = 32'h11112222;
    inst_bus.req   = 1'b1;
    inst_bus.addr  = 32'h00003000;
    data_bus.req   = 1'b1;
    data_bus.wr    = 1'b1;
    data_bus.wstrb = 4'b0011;
    data_bus.addr  = 32'h00001000;
    data_bus.wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL prio_data_grant got %b want 1", data_bus.addr_ok); end
    checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL prio_inst_blocked got %b want 0", inst_bus.addr_ok); end
    sb.push_back('{is_inst: 1'b0, chk: 1'b0, rdata: 32'h0});
    step();
    data_bus.req = 1'b0;
    data_bus.wr  = 1'b0;
    @(negedge clk);
    checks++; if (m_bus.req !== 1'b1) begin errors++; $display("FAIL prio_m_req got %b want 1", m_bus.req); end
    checks++; if (m_bus.wr !== 1'b1) begin errors++; $display("FAIL prio_m_wr got %b want 1", m_bus.wr); end
    checks++; if (m_bus.wstrb !== 4'b0011) begin errors++; $display("FAIL prio_m_wstrb got %b want 0011", m_bus.wstrb); end
    checks++; if (m_bus.addr !== 32'h00001000) begin errors++; $display("FAIL prio_m_addr got %h want 00001000", m_bus.addr); end
    checks++; if (m_bus.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_m_wdata got %h want deadbeef", m_bus.wdata); end
    checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL prio_no_grant_req got %b want 0", inst_bus.addr_ok); end
    step();
    @(negedge clk);
    checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL prio_store_data_ok got %b want 1", data_bus.data_ok); end
    checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL prio_no_grant_resp got %b want 0", inst_bus.addr_ok); end
    step();
    @(negedge clk);
    checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL prio_inst_grant got %b want 1", inst_bus.addr_ok); end
    sb.push_back('{is_inst: 1'b1, chk: 1'b1, rdata: 32'h11112222});
    step();
    inst_bus.req = 1'b0;
    @(negedge clk);
    checks++; if (m_bus.addr !== 32'h00003000) begin errors++; $display("FAIL prio_inst_m_addr got %h want 00003000", m_bus.addr); end
    checks++; if (m_bus.wr !== 1'b0) begin errors++; $display("FAIL prio_inst_m_wr got %b want 0", m_bus.wr); end
    step();
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL prio_sb_left got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_stall();
    data_bus.req   = 1'b1;
    data_bus.wr    = 1'b1;
    data_bus.wstrb = 4'b1100;
    data_bus.addr  = 32'h00004000;
    data_bus.wdata = 32'hA5A55A5A;
    @(negedge clk);
    checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL stall_grant got %b want 1", data_bus.addr_ok); end
    step();
    // New pending requests with different fields must neither be granted nor leak onto m
    data_bus.addr  = 32'h99990000;
    data_bus.wdata = 32'h00000000;
    data_bus.wstrb = 4'b1111;
    inst_bus.req   = 1'b1;
    inst_bus.addr  = 32'h00008000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (m_bus.req !== 1'b1) begin errors++; $display("FAIL stall_m_req cyc %0d got %b want 1", i, m_bus.req); end
      checks++;
      if (m_bus.addr !== 32'h00004000 || m_bus.wdata !== 32'hA5A55A5A || m_bus.wstrb !== 4'b1100) begin
        errors++;
        $display("FAIL stall_fields cyc %0d got %h/%h/%b want 00004000/a5a55a5a/1100", i, m_bus.addr, m_bus.wdata, m_bus.wstrb);
      end
      checks++;
      if (inst_bus.addr_ok !== 1'b0 || data_bus.addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL stall_addr_ok cyc %0d got %b%b want 00", i, inst_bus.addr_ok, data_bus.addr_ok);
      end
      step();
    end
    // data_ok together with addr_ok must be ignored
    m_bus.addr_ok = 1'b1;
    m_bus.data_ok = 1'b1;
    @(negedge clk);
    checks++; if (m_bus.req !== 1'b1) begin errors++; $display("FAIL stall_m_req_final got %b want 1", m_bus.req); end
    checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL stall_early_data_ok got %b want 0", data_bus.data_ok); end
    step();
    m_bus.addr_ok = 1'b0;
    m_bus.data_ok = 1'b0;
    @(negedge clk);
    checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL stall_resp_wait got %b want 0", data_bus.data_ok); end
    checks++; if (m_bus.req !== 1'b0) begin errors++; $display("FAIL stall_resp_m_req got %b want 0", m_bus.req); end
    step();
    m_bus.data_ok = 1'b1;
    data_bus.req  = 1'b0;
    inst_bus.req  = 1'b0;
    sb.push_back('{is_inst: 1'b0, chk: 1'b0, rdata: 32'h0});
    @(negedge clk);
    checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL stall_data_ok got %b want 1", data_bus.data_ok); end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_sb_left got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_flush();
    // Flush during RESP of a fetch
    m_bus.addr_ok = 1'b1;
    m_bus.data_ok = 1'b1;
    m_bus.rdata   = 32'h00000055;
    inst_bus.req  = 1'b1;
    inst_bus.addr = 32'h00000100;
    @(negedge clk);
    checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL flush_a_grant got %b want 1", inst_bus.addr_ok); end
    step();
    inst_bus.req = 1'b0;
    step();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL flush_resp_suppress got %b want 0", inst_bus.data_ok); end
    step();
    flush         = 1'b0;
    inst_bus.req  = 1'b1;
    inst_bus.addr = 32'h00000104;
    m_bus.rdata   = 32'h00000066;
    @(negedge clk);
    checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL flush_next_grant got %b want 1", inst_bus.addr_ok); end
    sb.push_back('{is_inst: 1'b1, chk: 1'b1, rdata: 32'h00000066});
    step();
    inst_bus.req = 1'b0;
    @(negedge clk);
    checks++; if (m_bus.addr !== 32'h00000104) begin errors++; $display("FAIL flush_next_addr got %h want 00000104", m_bus.addr); end
    step();
    step();
    // Flush only during REQ: the cancel flag must carry into RESP
    inst_bus.req  = 1'b1;
    inst_bus.addr = 32'h00000200;
    m_bus.rdata   = 32'h00000077;
    step();
    inst_bus.req = 1'b0;
    flush        = 1'b1;
    @(negedge clk);
    checks++; if (m_bus.req !== 1'b1) begin errors++; $display("FAIL flush_req_m_req got %b want 1", m_bus.req); end
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL flush_flag_suppress got %b want 0", inst_bus.data_ok); end
    step();
    // Flush during an inst request in IDLE: no grant; data unaffected
    flush         = 1'b1;
    inst_bus.req  = 1'b1;
    inst_bus.addr = 32'h00000300;
    @(negedge clk);
    checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL flush_idle_no_grant got %b want 0", inst_bus.addr_ok); end
    step();
    data_bus.req  = 1'b1;
    data_bus.addr = 32'h00000400;
    m_bus.rdata   = 32'h00000088;
    @(negedge clk);
    checks++; if (m_bus.req !== 1'b0) begin errors++; $display("FAIL flush_idle_m_req got %b want 0", m_bus.req); end
    checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL flush_data_grant got %b want 1", data_bus.addr_ok); end
    sb.push_back('{is_inst: 1'b0, chk: 1'b1, rdata: 32'h00000088});
    step();
    data_bus.req = 1'b0;
    inst_bus.req = 1'b0;
    @(negedge clk);
    checks++; if (m_bus.addr !== 32'h00000400) begin errors++; $display("FAIL flush_data_addr got %h want 00000400", m_bus.addr); end
    step();
    @(negedge clk);
    checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL flush_data_ok got %b want 1", data_bus.data_ok); end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL flush_sb_left got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_reset_resp();
    m_bus.addr_ok = 1'b1;
    m_bus.data_ok = 1'b0;
    data_bus.req  = 1'b1;
    data_bus.addr = 32'h00005000;
    @(negedge clk);
    checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL rstr_grant got %b want 1", data_bus.addr_ok); end
    step();
    data_bus.req = 1'b0;
    step();
    // Now in RESP: assert reset mid-cycle
    m_bus.data_ok = 1'b1;
    data_bus.req  = 1'b1;
    inst_bus.req  = 1'b1;
    resetn        = 1'b0;
    #1;
    checks++; if (m_bus.req !== 1'b0) begin errors++; $display("FAIL rstr_m_req got %b want 0", m_bus.req); end
    checks++;
    if (data_bus.data_ok !== 1'b0 || inst_bus.data_ok !== 1'b0) begin
      errors++;
      $display("FAIL rstr_data_ok got %b%b want 00", inst_bus.data_ok, data_bus.data_ok);
    end
    checks++;
    if (data_bus.addr_ok !== 1'b0 || inst_bus.addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL rstr_addr_ok got %b%b want 00", inst_bus.addr_ok, data_bus.addr_ok);
    end
    checks++; if (m_bus.addr !== 32'h0) begin errors++; $display("FAIL rstr_m_addr got %h want 0", m_bus.addr); end
    step();
    resetn       = 1'b1;
    data_bus.req = 1'b0;
    inst_bus.req = 1'b0;
    @(negedge clk);
    checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL rstr_late_data_ok got %b want 0", data_bus.data_ok); end
    checks++; if (m_bus.req !== 1'b0) begin errors++; $display("FAIL rstr_after_m_req got %b want 0", m_bus.req); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    m_bus.addr_ok = 1'b1;
    m_bus.data_ok = 1'b1;
    m_bus.rdata   = 32'hAAAA0001;
    data_bus.req  = 1'b1;
    data_bus.addr = 32'h00002000;
    @(negedge clk);
    checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_grant0 got %b want 1", data_bus.addr_ok); end
    sb.push_back('{is_inst: 1'b0, chk: 1'b1, rdata: 32'hAAAA0001});
    step();
    data_bus.addr = 32'h00002004;
    @(negedge clk);
    checks++; if (m_bus.addr !== 32'h00002000) begin errors++; $display("FAIL b2b_addr0 got %h want 00002000", m_bus.addr); end
    checks++; if (data_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL b2b_no_grant_req got %b want 0", data_bus.addr_ok); end
    checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL b2b_no_data_ok_req got %b want 0", data_bus.data_ok); end
    step();
    @(negedge clk);
    checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL b2b_data_ok0 got %b want 1", data_bus.data_ok); end
    checks++; if (data_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL b2b_no_grant_resp got %b want 0", data_bus.addr_ok); end
    step();
    m_bus.rdata = 32'hBBBB0002;
    @(negedge clk);
    checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_grant1 got %b want 1", data_bus.addr_ok); end
    checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", data_bus.data_ok); end
    sb.push_back('{is_inst: 1'b0, chk: 1'b1, rdata: 32'hBBBB0002});
    step();
    data_bus.req = 1'b0;
    @(negedge clk);
    checks++; if (m_bus.addr !== 32'h00002004) begin errors++; $display("FAIL b2b_addr1 got %h want 00002004", m_bus.addr); end
    step();
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_sb_left got %0d want 0", sb.size()); end
    checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL b2b_idle_data_ok got %b want 0", data_bus.data_ok); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_inst_fetch();
    test_priority();
    test_stall();
    test_flush();
    test_reset_resp();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
